wb_stage_mq: RTL
================

# wb_stage_mq

Parametrised write-back stage for the multi-issue MIPS pipeline. Accepts up to LANES completed results per cycle from MEM/WB and selects ALU result or load data per lane (with optional sub-word load extension). Results go into an in-order pending queue, which drains up to WPORTS entries per cycle onto the register-file write ports. It replaces the fixed I/R two-lane combinational write-back and adds back-pressure when the register file has fewer write ports than issue lanes.

## Interface
- LANES, 2, issue lanes entering write-back (1..4); lane 0 is the oldest instruction.
- WPORTS, 1, register-file write ports (1..LANES).
- DEPTH, 4, pending-queue entries (power of two, >= LANES).
- clk  in  1  pipeline clock; all state updates on its rising edge.
- btnc_i  in  1  reset, synchronous, active-high.
- valid_i  in  LANES  lane carries a register-writing result.
- rd_i  in  5*LANES  destination register per lane.
- memtoreg_i  in  LANES  1 = write load data, 0 = write ALU result.
- alu_result_i  in  32*LANES  ALU result per lane.
- read_data_i  in  32*LANES  raw memory word per lane.
- ld_size_i  in  2*LANES  00 word, 01 half, 10 byte (used only with WB_LOAD_EXT_EN).
- ld_unsigned_i  in  LANES  zero-extend sub-word load (used only with WB_LOAD_EXT_EN).
- ld_off_i  in  2*LANES  byte address offset of the load (used only with WB_LOAD_EXT_EN).
- stall_o  out  1  upstream must hold MEM/WB; inputs are ignored this cycle.
- we_o  out  WPORTS  write enable per register-file port.
- waddr_o  out  5*WPORTS  write address per port.
- wdata_o  out  32*WPORTS  write data per port.
- count_o  out  $clog2(DEPTH)+1  queue occupancy (debug).

## Operation
- Lane data: memtoreg_i ? load_value : alu_result_i.
- Enqueue: when stall_o=0, valid lanes with rd != 0 are written into the queue in lane order; lanes with rd=0 or valid=0 are dropped, and dropped lanes leave no slot gap.
- Drain: each cycle, the min(count, WPORTS) oldest entries drive write ports 0..k-1 in age order (port 0 oldest). Remaining ports have we=0, and their address and data are 0.
- Same-cycle same-rd conflict across ports: only the youngest drained entry asserts we. The older entries are still popped.
- count_next = count + enqueued - drained. Read and write pointers wrap modulo DEPTH.
- stall_o = (count - drained_this_cycle) > (DEPTH - LANES). It is combinational from registered state only, with no path from the *_i inputs.
- Overflow is impossible by construction. An assertion checks count <= DEPTH.

## Timing
- Latency: a lane accepted at edge N appears on the write ports in cycle N+1 at the earliest. It appears later if older entries are still queued.
- Throughput: WPORTS writes per cycle. With WPORTS = LANES and a continuously drained queue, stall_o never rises.
- Reset (btnc_i=1 at an edge): pointers and count go to 0. Outputs go to stall_o=0, we_o=0, waddr_o=0, wdata_o=0, count_o=0.
- Reset mid-operation: queued entries are discarded and not written. Inputs in the reset cycle are ignored.
- While stall_o=1, valid_i is ignored. The drain continues.

## Configuration
- WB_LOAD_EXT_EN defined: load_value is extracted from read_data_i using ld_off_i and ld_size_i (big-endian byte lanes, matching data memory). Byte and half values are sign-extended unless ld_unsigned_i is set. A half with ld_off_i[0]=1 uses offset & 2'b10.
- WB_LOAD_EXT_EN undefined: load_value = read_data_i, and the ld_* inputs are unused.

## Structure
- Package wb_pkg holds:
  - typedef wb_entry_t {rd[4:0], data[31:0]};
  - localparams LD_WORD=2'b00, LD_HALF=2'b01, LD_BYTE=2'b10;
  - REG_ZERO=5'd0.
- Sub-module wb_load_ext: purely combinational, one instance per lane, compiled only under WB_LOAD_EXT_EN.
- Queue storage: DEPTH x wb_entry_t register array. No RAM inference.

## Test plan
- Reset, then LANES=2 and WPORTS=2. Lane0 writes rd=3 with alu=0x11, lane1 writes rd=4 with load 0x22. Next cycle: we_o=2'b11, waddr={4,3}, wdata={0x22,0x11}.
- WPORTS=1, DEPTH=4, both lanes valid every cycle. Occupancy rises, and stall_o=1 from the cycle count-drained exceeds 2. Writes appear one per cycle in lane order, with no loss and no duplication.
- Lane0 rd=0 and lane1 rd=7 with 0x55. Only rd=7 is enqueued, and count increments by 1.
- WPORTS=2, both lanes rd=9 with 0xA then 0xB. Only port 1 asserts we, writing 0xB. Port 0 has we=0.
- With WB_LOAD_EXT_EN: word 0x80FF7F01, byte load at off=0, signed, gives 0xFFFFFF80. Half at off=2, unsigned, gives 0x00007F01.
- Fill the queue with 3 entries, then assert btnc_i for one cycle. The next cycle shows count_o=0, we_o=0 and stall_o=0, and the old entries are never written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the multi-issue write-back stage.
package wb_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [1:0] LD_WORD  = 2'b00;
    localparam logic [1:0] LD_HALF  = 2'b01;
    localparam logic [1:0] LD_BYTE  = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_ext.sv
// Sub-word load extraction for one lane, present only when WB_LOAD_EXT_EN is defined.
// Byte lanes are big-endian: offset 0 is bits [31:24].
`ifdef WB_LOAD_EXT_EN
module wb_load_ext
    import wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = 8'h00;
        case (off_i)
            2'd0:    byte_v = rdata_i[31:24];
            2'd1:    byte_v = rdata_i[23:16];
            2'd2:    byte_v = rdata_i[15:8];
            default: byte_v = rdata_i[7:0];
        endcase
        // A misaligned half falls back to its containing aligned half.
        half_v  = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        value_o = rdata_i;
        case (size_i)
            LD_HALF: value_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
            LD_BYTE: value_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
            default: value_o = rdata_i;
        endcase
    end

endmodule
`endif

// File: rtl/wb_stage_mq.sv
// Multi-lane write-back stage: per-lane result select, in-order pending queue,
// drain onto WPORTS register-file write ports. Optional feature: WB_LOAD_EXT_EN.
module wb_stage_mq
    import wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      btnc_i,
    input  logic [LANES-1:0]          valid_i,
    input  logic [5*LANES-1:0]        rd_i,
    input  logic [LANES-1:0]          memtoreg_i,
    input  logic [32*LANES-1:0]       alu_result_i,
    input  logic [32*LANES-1:0]       read_data_i,
    input  logic [2*LANES-1:0]        ld_size_i,
    input  logic [LANES-1:0]          ld_unsigned_i,
    input  logic [2*LANES-1:0]        ld_off_i,
    output logic                      stall_o,
    output logic [WPORTS-1:0]         we_o,
    output logic [5*WPORTS-1:0]       waddr_o,
    output logic [32*WPORTS-1:0]      wdata_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % DEPTH);
    endfunction

    logic [LANES-1:0][31:0] load_val;
    logic [LANES-1:0][31:0] lane_data;

`ifndef WB_LOAD_EXT_EN
    logic unused_ld;
    assign unused_ld = ^{ld_size_i, ld_unsigned_i, ld_off_i};
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef WB_LOAD_EXT_EN
        wb_load_ext u_ext (
            .rdata_i    (read_data_i[32*l +: 32]),
            .size_i     (ld_size_i[2*l +: 2]),
            .unsigned_i (ld_unsigned_i[l]),
            .off_i      (ld_off_i[2*l +: 2]),
            .value_o    (load_val[l])
        );
`else
        assign load_val[l] = read_data_i[32*l +: 32];
`endif
        assign lane_data[l] = memtoreg_i[l] ? load_val[l] : alu_result_i[32*l +: 32];
    end

    wb_entry_t       queue_q [DEPTH];
    wb_entry_t       queue_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    int              n_drain;
    int              n_enq;

    // Stall looks only at registered state so upstream never sees a loop through *_i.
    always_comb begin
        n_drain = (int'(count_q) < WPORTS) ? int'(count_q) : WPORTS;
        stall_o = (int'(count_q) - n_drain) > (DEPTH - LANES);
    end

    always_comb begin
        queue_d = queue_q;
        n_enq   = 0;
        if (!stall_o) begin
            for (int l = 0; l < LANES; l++) begin
                if (valid_i[l] && rd_i[5*l +: 5] != REG_ZERO) begin
                    queue_d[wrap(int'(wr_ptr_q) + n_enq)].rd   = rd_i[5*l +: 5];
                    queue_d[wrap(int'(wr_ptr_q) + n_enq)].data = lane_data[l];
                    n_enq++;
                end
            end
        end
        wr_ptr_d = wrap(int'(wr_ptr_q) + n_enq);
        rd_ptr_d = wrap(int'(rd_ptr_q) + n_drain);
        count_d  = CW'(int'(count_q) + n_enq - n_drain);
    end

    wb_entry_t ent;
    logic      keep;

    // An older drained entry is suppressed when a younger one in the same
    // cycle targets the same register; it is still popped.
    always_comb begin
        we_o    = '0;
        waddr_o = '0;
        wdata_o = '0;
        ent     = '0;
        keep    = 1'b0;
        for (int p = 0; p < WPORTS; p++) begin
            if (p < n_drain) begin
                ent  = queue_q[wrap(int'(rd_ptr_q) + p)];
                keep = 1'b1;
                for (int q = p + 1; q < WPORTS; q++) begin
                    if (q < n_drain && queue_q[wrap(int'(rd_ptr_q) + q)].rd == ent.rd) begin
                        keep = 1'b0;
                    end
                end
                we_o[p]             = keep;
                waddr_o[5*p +: 5]   = ent.rd;
                wdata_o[32*p +: 32] = ent.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btnc_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

    always_ff @(posedge clk) begin
        if (!btnc_i) begin
            assert (int'(count_q) <= DEPTH);
        end
    end

    assign count_o = count_q;

endmodule
